jtag_master_seq: RTL and testbench

Synthesizable JTAG master sequencer that turns single-beat scan commands into TCK/TMS/TDI bit sequences and collects TDO. It sits between an on-chip host (debug mailbox, test controller) and the JTAG pins of the core-debug TAP. It derives TCK from the system clock, tracks the TAP controller position, and always leaves the TAP in Run-Test/Idle after a command.

---
 rtl/jtag_master_pkg.sv | 61 ++++++
 rtl/jtag_tck_gen.sv | 40 ++++
 rtl/jtag_master_seq.sv | 123 ++++++++++++
 tb/tb_jtag_master_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_master_pkg.sv
// Shared types and TMS patterns for the JTAG master sequencer.
// A pattern's bit k is the TMS value of tick k of that segment.
package jtag_master_pkg;

   typedef enum logic [1:0] {
      OP_RESET   = 2'd0,
      OP_SCAN_IR = 2'd1,
      OP_SCAN_DR = 2'd2,
      OP_RSVD    = 2'd3
   } jtag_op_e;

   localparam int         JTAG_RESET_TICKS = 6;
   localparam logic [7:0] RESET_TMS        = 8'b0001_1111;
   localparam int         IR_HDR_LEN       = 4;
   localparam logic [7:0] IR_HDR_TMS       = 8'b0000_0011;
   localparam int         DR_HDR_LEN       = 3;
   localparam logic [7:0] DR_HDR_TMS       = 8'b0000_0001;
   localparam int         TRL_LEN          = 2;
   localparam logic [7:0] TRL_TMS          = 8'b0000_0001;

   typedef struct packed {
      logic       tms;
      logic       shift;
      logic [4:0] bit_idx;
      logic       last;
   } tick_t;

   function automatic logic bit_at(input logic [7:0] pat, input int k);
      logic [7:0] s;
      s = pat >> k;
      return s[0];
   endfunction

   // What tick idx of a command looks like: TMS, whether it shifts a data bit, and which one.
   function automatic tick_t tick_decode(input jtag_op_e op, input logic [4:0] len,
                                         input logic [5:0] idx);
      tick_t t;
      int    k;
      int    hdr;
      int    n_shift;
      t       = '0;
      k       = int'(idx);
      n_shift = int'(len) + 1;
      hdr     = (op == OP_SCAN_IR) ? IR_HDR_LEN : DR_HDR_LEN;
      if (op == OP_RESET) begin
         t.tms  = bit_at(RESET_TMS, k);
         t.last = (k == JTAG_RESET_TICKS - 1);
      end else if (k < hdr) begin
         t.tms = bit_at((op == OP_SCAN_IR) ? IR_HDR_TMS : DR_HDR_TMS, k);
      end else if (k < hdr + n_shift) begin
         t.shift   = 1'b1;
         t.bit_idx = 5'(k - hdr);
         t.tms     = (k == hdr + n_shift - 1);
      end else begin
         t.tms  = bit_at(TRL_TMS, k - hdr - n_shift);
         t.last = (k == hdr + n_shift + TRL_LEN - 1);
      end
      return t;
   endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK phase generator: CLK_DIV cycles low then CLK_DIV cycles high while active.
// Strobes mark the last cycle of each phase; tck itself comes straight from a flop.
module jtag_tck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   output logic tck,
   output logic fall_stb,
   output logic rise_stb
);

   localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] PH_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          ph_end;

   assign ph_end   = active & (cnt == PH_LAST);
   assign rise_stb = ph_end & ~tck;
   assign fall_stb = ph_end & tck;

   // NOTE: state updates use <= so every flop samples pre-edge values, whatever the statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         tck <= 1'b0;
      end else if (!active) begin
         cnt <= '0;
         tck <= 1'b0;
      end else if (ph_end) begin
         cnt <= '0;
         tck <= ~tck;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/jtag_master_seq.sv
// JTAG master sequencer: expands one RESET/SCAN_IR/SCAN_DR command into TCK ticks,
// captures TDO during shift ticks and always returns the TAP to Run-Test/Idle.
module jtag_master_seq
   import jtag_master_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [4:0]        cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_data,
   output logic              tck,
   output logic              tms,
   output logic              tdi,
   input  logic              tdo,
   output logic              busy,
   output logic              tap_idle
);

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_RESP} state_e;

   state_e            state, state_nxt;
   jtag_op_e          op_in, op_q, dec_op;
   logic [4:0]        len_q, dec_len;
   logic [5:0]        tick_q, dec_idx;
   logic [DATA_W-1:0] data_q, dec_data;
   tick_t             cur_q, dec;
   logic              accept, reject, fall_stb, rise_stb;

   assign op_in     = jtag_op_e'(cmd_op);
   assign cmd_ready = ((state == S_IDLE) | (state == S_RESP)) & rst_n;
   assign accept    = cmd_valid & cmd_ready;
   // A scan only makes sense from a known Run-Test/Idle position.
   assign reject    = (op_in == OP_RSVD) | ((op_in != OP_RESET) & ~tap_idle);
   assign busy      = (state == S_LOW) | (state == S_HIGH);
   assign rsp_valid = (state == S_RESP);
   assign tms       = cur_q.tms;

   jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .active   (busy),
      .tck      (tck),
      .fall_stb (fall_stb),
      .rise_stb (rise_stb)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      dec_op    = op_q;
      dec_len   = len_q;
      dec_idx   = tick_q + 6'd1;
      dec_data  = data_q;
      if (accept) begin
         dec_op   = op_in;
         dec_len  = cmd_len;
         dec_idx  = 6'd0;
         dec_data = cmd_data;
      end
      case (state)
         S_IDLE, S_RESP: begin
            if (accept) state_nxt = reject ? S_RESP : S_LOW;
            else        state_nxt = S_IDLE;
         end
         S_LOW:   if (rise_stb) state_nxt = S_HIGH;
         S_HIGH:  if (fall_stb) state_nxt = cur_q.last ? S_RESP : S_LOW;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign dec = tick_decode(dec_op, dec_len, dec_idx);

   // Next-tick TMS/TDI are loaded on entry to LOW: at acceptance or at the end of HIGH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_q    <= '{tms: 1'b1, shift: 1'b0, bit_idx: 5'd0, last: 1'b0};
         tdi      <= 1'b0;
         op_q     <= OP_RESET;
         len_q    <= '0;
         data_q   <= '0;
         tick_q   <= '0;
         rsp_err  <= 1'b0;
         rsp_data <= '0;
         tap_idle <= 1'b0;
      end else if (accept) begin
         rsp_err  <= reject;
         rsp_data <= '0;
         if (!reject) begin
            op_q     <= op_in;
            len_q    <= cmd_len;
            data_q   <= cmd_data;
            tick_q   <= '0;
            cur_q    <= dec;
            tdi      <= dec.shift & dec_data[dec.bit_idx];
            tap_idle <= 1'b0;
         end
      end else if (rise_stb) begin
         if (cur_q.shift) rsp_data[cur_q.bit_idx] <= tdo;
      end else if (fall_stb) begin
         if (cur_q.last) begin
            tap_idle <= 1'b1;
         end else begin
            tick_q <= dec_idx;
            cur_q  <= dec;
            tdi    <= dec.shift & dec_data[dec.bit_idx];
         end
      end
   end

endmodule

// File: tb/tb_jtag_master_seq.sv
// Bench for jtag_master_seq: a behavioural TAP on the pins plus an arithmetic
// reference for TMS/TDI streams, response data, errors and latency.
module tb_jtag_master_seq;

   localparam int          D         = 2;
   localparam int          W         = 32;
   localparam logic [7:0]  IR_BYPASS = 8'hFF;
   localparam logic [7:0]  IR_IDCODE = 8'h0E;
   localparam logic [31:0] IDCODE    = 32'h4BA0_0477;

   logic         clk, rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_err;
   logic [1:0]   cmd_op;
   logic [4:0]   cmd_len;
   logic [W-1:0] cmd_data, rsp_data;
   logic         tck, tms, tdi, tdo, busy, tap_idle;

   int n_total = 0;
   int n_bad   = 0;

   jtag_master_seq #(.CLK_DIV(D), .DATA_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
      .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy), .tap_idle(tap_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural TAP ----------------
   typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
                     SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_e;
   tap_e        tst   = PAUDR;
   logic [7:0]  ir    = IR_IDCODE;
   logic [7:0]  ir_sr = 8'h00;
   logic [31:0] dr_sr = 32'h0;
   logic        bp    = 1'b0;
   logic        tms_q[$];
   logic        tdi_q[$];

   always @(posedge tck) begin
      tms_q.push_back(tms);
      tdi_q.push_back(tdi);
      case (tst)
         TLR:   begin ir <= IR_IDCODE; tst <= tms ? TLR : RTI; end
         RTI:   tst <= tms ? SELDR : RTI;
         SELDR: tst <= tms ? SELIR : CAPDR;
         CAPDR: begin
            if (ir == IR_BYPASS) bp <= 1'b0; else dr_sr <= IDCODE;
            tst <= tms ? EX1DR : SHDR;
         end
         SHDR:  begin
            if (ir == IR_BYPASS) bp <= tdi; else dr_sr <= {tdi, dr_sr[31:1]};
            tst <= tms ? EX1DR : SHDR;
         end
         EX1DR: tst <= tms ? UPDR : PAUDR;
         PAUDR: tst <= tms ? EX2DR : PAUDR;
         EX2DR: tst <= tms ? UPDR : SHDR;
         UPDR:  tst <= tms ? SELDR : RTI;
         SELIR: tst <= tms ? TLR : CAPIR;
         CAPIR: begin ir_sr <= 8'h01; tst <= tms ? EX1IR : SHIR; end
         SHIR:  begin ir_sr <= {tdi, ir_sr[7:1]}; tst <= tms ? EX1IR : SHIR; end
         EX1IR: tst <= tms ? UPIR : PAUIR;
         PAUIR: tst <= tms ? EX2IR : PAUIR;
         EX2IR: tst <= tms ? UPIR : SHIR;
         UPIR:  begin ir <= ir_sr; tst <= tms ? SELDR : RTI; end
         default: tst <= TLR;
      endcase
   end

   always @(negedge tck)
      tdo <= (tst == SHDR) ? ((ir == IR_BYPASS) ? bp : dr_sr[0]) :
             (tst == SHIR) ? ir_sr[0] : 1'b0;

   // ---------------- reference model ----------------
   logic [7:0]  ref_ir   = IR_IDCODE;
   bit          ref_idle = 1'b0;
   logic [31:0] last_rsp;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected TMS/TDI streams from the command rules.
   task automatic exp_seq(input int op, input int len, input logic [31:0] data,
                          output logic [63:0] tv, output logic [63:0] dv, output int n);
      int hdr;
      int l;
      tv = '0; dv = '0; l = len + 1;
      if (op == 0) begin
         tv = 64'b01_1111;
         n  = 6;
      end else begin
         tv[0] = 1'b1;
         if (op == 1) tv[1] = 1'b1;
         hdr = (op == 1) ? 4 : 3;
         for (int i = 0; i < l; i++) begin
            dv[hdr+i] = data[i];
            if (i == l - 1) tv[hdr+i] = 1'b1;
         end
         tv[hdr+l] = 1'b1;
         n = hdr + l + 2;
      end
   endtask

   function automatic logic [31:0] exp_rsp(input int op, input int len, input logic [31:0] data);
      logic [63:0] mask;
      mask = (64'd1 << (len + 1)) - 64'd1;
      if (op == 1)                return 32'(64'h01 & mask);
      else if (op == 0)           return 32'h0;
      else if (ref_ir == IR_BYPASS) return 32'(({32'h0, data} << 1) & mask);
      else                        return 32'({32'h0, IDCODE} & mask);
   endfunction

   task automatic wait_rsp(output int lat, output logic err, output logic [31:0] d);
      lat = -1; err = 1'bx; d = 'x;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = k; err = rsp_err; d = rsp_data;
            break;
         end
      end
   endtask

   task automatic pack_and_check(input string tag, input logic [63:0] tv, input logic [63:0] dv,
                                 input int n);
      logic [63:0] ot, od;
      ot = '0; od = '0;
      for (int i = 0; i < tms_q.size() && i < 64; i++) begin
         ot[i] = tms_q[i];
         od[i] = tdi_q[i];
      end
      check({tag, "_ticks"}, 64'(tms_q.size()), 64'(n));
      check({tag, "_tms"}, ot, tv);
      check({tag, "_tdi"}, od, dv);
   endtask

   task automatic do_cmd(input string tag, input int op, input int len, input logic [31:0] data);
      bit          rej;
      int          lat, n;
      logic        err;
      logic [31:0] d, ed;
      logic [63:0] tv, dv;
      rej = (op == 3) || (op != 0 && !ref_idle);
      tms_q.delete(); tdi_q.delete();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'(op); cmd_len = 5'(len); cmd_data = data;
      for (int k = 0; k < 100 && !cmd_ready; k++) @(negedge clk);
      if (!cmd_ready) check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_len = 5'($urandom); cmd_data = $urandom;
      wait_rsp(lat, err, d);
      if (rej) begin
         tv = '0; dv = '0; n = 0; ed = '0;
      end else begin
         exp_seq(op, len, data, tv, dv, n);
         ed = exp_rsp(op, len, data);
      end
      check({tag, "_lat"}, 64'(lat), rej ? 64'd1 : 64'(n * 2 * D + 1));
      check({tag, "_err"}, 64'(err), 64'(rej));
      check({tag, "_data"}, 64'(d), 64'(ed));
      pack_and_check(tag, tv, dv, n);
      @(negedge clk);
      check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
      last_rsp = d;
      if (!rej) begin
         if (op == 0) begin ref_ir = IR_IDCODE; ref_idle = 1'b1; end
         if (op == 1) ref_ir = data[7:0];
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          lat, n, op, len;
      logic        err;
      logic [31:0] d, data;
      logic [63:0] tv, dv;

      tdo = 1'b0;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 5'd0; cmd_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tck", 64'(tck), 64'd0);
      check("rst_tms", 64'(tms), 64'd1);
      check("rst_tdi", 64'(tdi), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_err", 64'(rsp_err), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_tap_idle", 64'(tap_idle), 64'd0);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_cmd("dr_before_reset", 2, 7, 32'hA5);
      do_cmd("op3_before_reset", 3, 0, 32'h0);
      do_cmd("reset", 0, 0, 32'h0);
      check("reset_tap_idle", 64'(tap_idle), 64'd1);
      do_cmd("ir_cdpacc", 1, 7, 32'h05);
      check("ir_cdpacc_cap", 64'(last_rsp), 64'h01);
      do_cmd("ir_bypass", 1, 7, 32'(IR_BYPASS));
      do_cmd("dr_bypass", 2, 7, 32'hA5);
      check("dr_bypass_a5", 64'(last_rsp), 64'h4A);
      do_cmd("ir_idcode", 1, 7, 32'(IR_IDCODE));
      do_cmd("dr_idcode", 2, 31, 32'h0);
      check("dr_idcode_val", 64'(last_rsp), 64'(IDCODE));
      do_cmd("op3_idle", 3, 5, 32'h1234);

      // Back-to-back: second command waits on cmd_valid and is taken during RESP.
      tms_q.delete(); tdi_q.delete();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 5'd0; cmd_data = '0;
      @(posedge clk);
      #1;
      cmd_op = 2'd1; cmd_len = 5'd7; cmd_data = 32'(IR_BYPASS);
      wait_rsp(lat, err, d);
      check("b2b_first_lat", 64'(lat), 64'(6 * 2 * D + 1));
      check("b2b_ready_in_resp", 64'(cmd_ready), 64'd1);
      tms_q.delete(); tdi_q.delete();
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      ref_ir = IR_IDCODE; ref_idle = 1'b1;
      wait_rsp(lat, err, d);
      exp_seq(1, 7, 32'(IR_BYPASS), tv, dv, n);
      check("b2b_second_lat", 64'(lat), 64'(n * 2 * D + 1));
      check("b2b_second_data", 64'(d), 64'(exp_rsp(1, 7, 32'(IR_BYPASS))));
      pack_and_check("b2b_second", tv, dv, n);
      ref_ir = IR_BYPASS;

      // Randomized command mix.
      for (int it = 0; it < 24; it++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            op = 3; len = int'($urandom_range(0, 31)); data = $urandom;
         end else if (r == 1) begin
            op = 0; len = 0; data = 0;
         end else if (r <= 4) begin
            op = 1; len = 7; data = $urandom_range(0, 1) ? 32'(IR_BYPASS) : 32'(IR_IDCODE);
         end else begin
            op = 2; len = int'($urandom_range(0, 31)); data = $urandom;
         end
         do_cmd("rand", op, len, data);
      end

      // Reset in the middle of a 32-bit DR scan.
      tms_q.delete(); tdi_q.delete();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 5'd31; cmd_data = $urandom;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (int k = 0; k < 1000 && tms_q.size() < 10; k++) begin
         @(posedge clk);
         #1;
      end
      check("abort_reached_tick10", 64'(tms_q.size()), 64'd10);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_tck", 64'(tck), 64'd0);
      check("abort_tms", 64'(tms), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_tap_idle", 64'(tap_idle), 64'd0);
      check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
      ref_idle = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready_after", 64'(cmd_ready), 64'd1);
      do_cmd("abort_dr_rejected", 2, 7, 32'h5A);
      do_cmd("abort_reset", 0, 0, 32'h0);
      do_cmd("abort_ir_idcode", 1, 7, 32'(IR_IDCODE));
      do_cmd("abort_dr_idcode", 2, 31, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
